tile_map_writer: RTL

- Write side of the packed tile-map BRAM that the VGA renderer reads: 16-bit words, four 4-bit cell codes per word.
- Accepts single-cell update requests from game logic over a valid/ready handshake.
- Performs a read-modify-write of the containing word, so the other three cells are preserved.
- Also supports a bulk board clear. Drives the write port of the shared SB_RAM40_4K and its address.

---
 rtl/tile_map_pkg.sv | 26 ++
 rtl/tile_word_merge.sv | 20 ++
 rtl/tile_map_writer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tile_map_pkg.sv
// Shared constants, cell codes and FSM state encoding for the tile-map write side.
package tile_map_pkg;

  localparam int GRID_W         = 20;
  localparam int GRID_H         = 15;
  localparam int WORDS_PER_ROW  = 5;
  localparam int CELLS_PER_WORD = 4;
  localparam int CELL_BITS      = 4;
  localparam int ADDR_W         = 11;
  localparam int WORD_W         = CELLS_PER_WORD * CELL_BITS;

  localparam logic [CELL_BITS-1:0] CELL_RED   = 4'h0;
  localparam logic [CELL_BITS-1:0] CELL_GREEN = 4'h1;
  localparam logic [CELL_BITS-1:0] CELL_BLUE  = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WRITE   = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_ERR     = 3'd5,
    ST_VERIFY  = 3'd6
  } state_t;

endpackage

// File: rtl/tile_word_merge.sv
// Replaces one 4-bit cell inside a packed 16-bit tile-map word; purely combinational.
import tile_map_pkg::*;

module tile_word_merge (
  input  logic [WORD_W-1:0]    word_i,
  input  logic [1:0]           nib_i,
  input  logic [CELL_BITS-1:0] code_i,
  output logic [WORD_W-1:0]    merged_o
);

  logic [3:0]        shamt;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] ins;

  assign shamt    = {nib_i, 2'b00};
  assign mask     = 16'h000F << shamt;
  assign ins      = {12'h000, code_i} << shamt;
  assign merged_o = (word_i & ~mask) | ins;

endmodule

// File: rtl/tile_map_writer.sv
// Write-side controller for the packed tile-map BRAM: per-cell read-modify-write and bulk clear.
// Define TILE_WRITER_READBACK_EN to re-read and check each written word before signalling done.
//
// state    | meaning
// IDLE     | ready for a request; clear request has priority
// RD_ADDR  | word address presented to the BRAM read port
// RD_DATA  | read data valid; merged word registered
// WRITE    | single-cycle write of the merged word
// CLEAR    | fill one word per cycle with the replicated clear code
// ERR      | out-of-range request rejected, error pulse
// VERIFY   | (readback build) two-cycle re-read and compare
import tile_map_pkg::*;

module tile_map_writer #(
  parameter int GRID_W        = tile_map_pkg::GRID_W,
  parameter int GRID_H        = tile_map_pkg::GRID_H,
  parameter int WORDS_PER_ROW = tile_map_pkg::WORDS_PER_ROW,
  parameter int BASE_ADDR     = 0
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Req_Valid,
  output logic                 o_Req_Ready,
  input  logic [4:0]           i_Cell_X,
  input  logic [3:0]           i_Cell_Y,
  input  logic [CELL_BITS-1:0] i_Cell_Code,
  input  logic                 i_Clear_Req,
  input  logic [CELL_BITS-1:0] i_Clear_Code,
  output logic [ADDR_W-1:0]    o_Bram_Addr,
  input  logic [WORD_W-1:0]    i_Bram_RData,
  output logic [WORD_W-1:0]    o_Bram_WData,
  output logic                 o_Bram_WE,
  output logic                 o_Done,
  output logic                 o_Error
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + GRID_H * WORDS_PER_ROW - 1);
  localparam logic [ADDR_W-1:0] WPR       = ADDR_W'(WORDS_PER_ROW);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [1:0]             nib_q, nib_d;
  logic [CELL_BITS-1:0]   code_q, code_d;
`ifdef TILE_WRITER_READBACK_EN
  logic                   phase_q, phase_d;
  logic                   mismatch;
`endif

  logic [ADDR_W-1:0]      req_addr;
  logic                   req_oob;
  logic [WORD_W-1:0]      merged;

  assign req_addr = BASE + ({7'd0, i_Cell_Y} * WPR) + {8'd0, i_Cell_X[4:2]};
  assign req_oob  = (i_Cell_X >= 5'(GRID_W)) || (i_Cell_Y >= 4'(GRID_H));

  tile_word_merge u_merge (
    .word_i   (i_Bram_RData),
    .nib_i    (nib_q),
    .code_i   (code_q),
    .merged_o (merged)
  );

`ifdef TILE_WRITER_READBACK_EN
  // Merged-vs-written catches the untouched nibbles; read-vs-merged catches the written one.
  assign mismatch = (merged != wdata_q) || (i_Bram_RData != merged);
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nib_q   <= '0;
      code_q  <= '0;
`ifdef TILE_WRITER_READBACK_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      nib_q   <= nib_d;
      code_q  <= code_d;
`ifdef TILE_WRITER_READBACK_EN
      phase_q <= phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    nib_d   = nib_q;
    code_d  = code_q;
`ifdef TILE_WRITER_READBACK_EN
    phase_d = phase_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_Clear_Req) begin
          code_d  = i_Clear_Code;
          addr_d  = BASE;
          wdata_d = {CELLS_PER_WORD{i_Clear_Code}};
          we_d    = 1'b1;
          state_d = ST_CLEAR;
        end else if (i_Req_Valid) begin
          nib_d  = i_Cell_X[1:0];
          code_d = i_Cell_Code;
          if (req_oob) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            addr_d  = req_addr;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        wdata_d = merged;
        we_d    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
`ifdef TILE_WRITER_READBACK_EN
        phase_d = 1'b0;
        state_d = ST_VERIFY;
`else
        done_d  = 1'b1;
        state_d = ST_IDLE;
`endif
      end
`ifdef TILE_WRITER_READBACK_EN
      ST_VERIFY: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          err_d   = mismatch;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
          we_d   = 1'b1;
        end
      end
      ST_ERR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_Req_Ready  = (state_q == ST_IDLE);
  assign o_Bram_Addr  = addr_q;
  assign o_Bram_WData = wdata_q;
  assign o_Bram_WE    = we_q;
  assign o_Done       = done_q;
  assign o_Error      = err_q;

endmodule
